// File: rtl/wbram_pkg.sv
// Shared types and parameter-word layout for the weight BRAM read sequencer.
package wbram_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PADDR,
    S_PDATA,
    S_WAITBUF,
    S_STREAM,
    S_DRAIN,
    S_RELEASE
  } state_t;

  // Layer parameter word is {last, reps-1, words-1}; words field sits at the LSB end.
  localparam int WORDS_LSB = 0;

  function automatic int reps_lsb(input int ww);
    return ww;
  endfunction

  function automatic int last_pos(input int ww, input int rep_w);
    return ww + rep_w;
  endfunction

  function automatic int param_width(input int ww, input int rep_w);
    return 1 + rep_w + ww;
  endfunction

endpackage

// File: rtl/wbram_word_fifo.sv
// Small synchronous FIFO holding full BRAM words between the read pipeline and the unpacker.
module wbram_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           rd_en,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             wr_ok, rd_ok;

  assign empty   = (count == '0);
  assign wr_ok   = wr_en && (count != CW'(DEPTH));
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      if (wr_ok && !rd_ok)      count <= count + 1'b1;
      else if (rd_ok && !wr_ok) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/wbram_rd_sequencer.sv
// Per-layer weight streamer: fetch layer params, claim a full buffer, read it back
// reps times across all banks in lockstep, unpack words into per-bank weight beats.
//   state     | meaning
//   IDLE      | waiting for start
//   PADDR     | requesting params for the current layer
//   PDATA     | waiting for {last, reps-1, words-1}
//   WAITBUF   | waiting for a full buffer index
//   STREAM    | issuing BRAM reads under FIFO credit
//   DRAIN     | reads done, emptying pipeline and FIFO
//   RELEASE   | handing the buffer back
module wbram_rd_sequencer
  import wbram_pkg::*;
#(
  parameter int STREAM_WIDTH   = 128,
  parameter int WEIGHT_BIT     = 8,
  parameter int NUM_BANKS      = 16,
  parameter int NUM_BUFS       = 2,
  parameter int BUF_DEPTH      = 512,
  parameter int BRAM_LATENCY   = 2,
  parameter int MAX_NUM_LAYERS = 4,
  parameter int REP_W          = 8
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            start,
  output logic [NUM_BANKS*$clog2(NUM_BUFS*BUF_DEPTH)-1:0] addrB,
  output logic [NUM_BANKS-1:0]                            enaB,
  output logic [NUM_BANKS-1:0]                            weB,
  input  logic [NUM_BANKS*STREAM_WIDTH-1:0]               diB,
  input  logic [$clog2(NUM_BUFS)-1:0]                     buf_ptr_data_l,
  input  logic                                            buf_ptr_valid_l,
  output logic                                            buf_ptr_ready_l,
  output logic [$clog2(NUM_BUFS)-1:0]                     buf_ptr_data_r,
  output logic                                            buf_ptr_valid_r,
  input  logic                                            buf_ptr_ready_r,
  output logic [$clog2(MAX_NUM_LAYERS):0]                 param_addr_l,
  output logic                                            param_addr_valid_l,
  input  logic                                            param_addr_ready_l,
  input  logic [param_width($clog2(BUF_DEPTH), REP_W)-1:0] param_data_l,
  input  logic                                            param_data_valid_l,
  output logic                                            param_data_ready_l,
  output logic [NUM_BANKS*WEIGHT_BIT-1:0]                 w_sys_data,
  output logic                                            w_sys_valid,
  input  logic                                            w_sys_ready,
  output logic                                            busy
);

  localparam int ELEMS      = STREAM_WIDTH / WEIGHT_BIT;
  localparam int BW         = $clog2(NUM_BUFS);
  localparam int WW         = $clog2(BUF_DEPTH);
  localparam int AW         = $clog2(NUM_BUFS * BUF_DEPTH);
  localparam int LW         = $clog2(MAX_NUM_LAYERS) + 1;
  localparam int KW         = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam int FIFO_DEPTH = BRAM_LATENCY + 2;
  localparam int CW         = $clog2(FIFO_DEPTH + 1);
  localparam int OW         = CW + 1;
  localparam int DW         = NUM_BANKS * STREAM_WIDTH;
  localparam int REPS_LSB   = reps_lsb(WW);
  localparam int LAST_POS   = last_pos(WW, REP_W);

  state_t                  state, state_nxt;
  logic [LW-1:0]           layer;
  logic [WW-1:0]           words_m1, word_idx;
  logic [REP_W-1:0]        reps_m1, rep_idx;
  logic                    last_flag;
  logic [BW-1:0]           buf_idx;
  logic [BRAM_LATENCY-1:0] rd_pipe;
  logic [KW-1:0]           elem_idx;
  logic [OW-1:0]           outstanding;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_empty;
  logic [DW-1:0]           fifo_head;
  logic                    issue, last_word, last_rep, final_layer, beat, pop;

  always_comb begin
    outstanding = '0;
    for (int i = 0; i < BRAM_LATENCY; i++) outstanding = outstanding + OW'(rd_pipe[i]);
  end

  // Credit check counts reads in flight so the FIFO can always absorb them.
  assign issue       = (state == S_STREAM) &&
                       ((outstanding + OW'(fifo_count)) < OW'(FIFO_DEPTH));
  assign last_word   = (word_idx == words_m1);
  assign last_rep    = (rep_idx == reps_m1);
  assign final_layer = last_flag || (layer == LW'(MAX_NUM_LAYERS - 1));
  assign w_sys_valid = !fifo_empty;
  assign beat        = w_sys_valid && w_sys_ready;
  assign pop         = beat && (elem_idx == KW'(ELEMS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    param_addr_valid_l = 1'b0;
    param_data_ready_l = 1'b0;
    buf_ptr_ready_l    = 1'b0;
    buf_ptr_valid_r    = 1'b0;
    case (state)
      S_IDLE:    if (start) state_nxt = S_PADDR;
      S_PADDR: begin
        param_addr_valid_l = 1'b1;
        if (param_addr_ready_l) state_nxt = S_PDATA;
      end
      S_PDATA: begin
        param_data_ready_l = 1'b1;
        if (param_data_valid_l) state_nxt = S_WAITBUF;
      end
      S_WAITBUF: begin
        buf_ptr_ready_l = 1'b1;
        if (buf_ptr_valid_l) state_nxt = S_STREAM;
      end
      S_STREAM:  if (issue && last_word && last_rep) state_nxt = S_DRAIN;
      S_DRAIN:   if ((outstanding == '0) && fifo_empty && (elem_idx == '0)) state_nxt = S_RELEASE;
      S_RELEASE: begin
        buf_ptr_valid_r = 1'b1;
        if (buf_ptr_ready_r) state_nxt = final_layer ? S_IDLE : S_PADDR;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layer     <= '0;
      words_m1  <= '0;
      reps_m1   <= '0;
      last_flag <= 1'b0;
      buf_idx   <= '0;
      word_idx  <= '0;
      rep_idx   <= '0;
      rd_pipe   <= '0;
      elem_idx  <= '0;
    end else begin
      if (state == S_IDLE && start) layer <= '0;
      if (state == S_RELEASE && buf_ptr_ready_r && !final_layer) layer <= layer + 1'b1;
      if (state == S_PDATA && param_data_valid_l) begin
        words_m1  <= param_data_l[WORDS_LSB +: WW];
        reps_m1   <= param_data_l[REPS_LSB +: REP_W];
        last_flag <= param_data_l[LAST_POS];
      end
      if (state == S_WAITBUF && buf_ptr_valid_l) begin
        buf_idx  <= buf_ptr_data_l;
        word_idx <= '0;
        rep_idx  <= '0;
      end
      if (issue) begin
        if (last_word) begin
          word_idx <= '0;
          rep_idx  <= rep_idx + 1'b1;
        end else begin
          word_idx <= word_idx + 1'b1;
        end
      end
      rd_pipe[0] <= issue;
      for (int i = 1; i < BRAM_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
      if (beat) elem_idx <= (elem_idx == KW'(ELEMS - 1)) ? '0 : elem_idx + 1'b1;
    end
  end

  wbram_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DW)
  ) u_word_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (rd_pipe[BRAM_LATENCY-1]),
    .wr_data (diB),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    addrB      = '0;
    w_sys_data = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      addrB[b*AW +: AW] = AW'({buf_idx, word_idx});
      if (!fifo_empty)
        w_sys_data[b*WEIGHT_BIT +: WEIGHT_BIT] =
          fifo_head[b*STREAM_WIDTH + int'(elem_idx)*WEIGHT_BIT +: WEIGHT_BIT];
    end
  end

  assign enaB           = {NUM_BANKS{issue}};
  assign weB            = '0;
  assign param_addr_l   = layer;
  assign buf_ptr_data_r = buf_idx;
  assign busy           = (state != S_IDLE);

endmodule

// File: tb/tb_wbram_rd_sequencer.sv
// Directed/randomized bench for wbram_rd_sequencer against a layer-level reference model.
module tb_wbram_rd_sequencer;

  localparam int SW = 32, WB = 8, NB = 2, NBUF = 2, DEPTH = 512, LAT = 2, MAXL = 4, REP_W = 8;
  localparam int ELEMS = SW / WB, WW = 9, AW = 10, PW = 1 + REP_W + WW, LW = 3;

  logic clk = 1'b0;
  logic rst_n, start;
  logic [NB*AW-1:0] addrB;
  logic [NB-1:0]    enaB, weB;
  logic [NB*SW-1:0] diB;
  logic             buf_ptr_data_l, buf_ptr_valid_l, buf_ptr_ready_l;
  logic             buf_ptr_data_r, buf_ptr_valid_r, buf_ptr_ready_r;
  logic [LW-1:0]    param_addr_l;
  logic             param_addr_valid_l, param_addr_ready_l;
  logic [PW-1:0]    param_data_l;
  logic             param_data_valid_l, param_data_ready_l;
  logic [NB*WB-1:0] w_sys_data;
  logic             w_sys_valid, w_sys_ready, busy;

  always #5 clk = ~clk;

  wbram_rd_sequencer #(
    .STREAM_WIDTH(SW), .WEIGHT_BIT(WB), .NUM_BANKS(NB), .NUM_BUFS(NBUF),
    .BUF_DEPTH(DEPTH), .BRAM_LATENCY(LAT), .MAX_NUM_LAYERS(MAXL), .REP_W(REP_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .addrB(addrB), .enaB(enaB), .weB(weB), .diB(diB),
    .buf_ptr_data_l(buf_ptr_data_l), .buf_ptr_valid_l(buf_ptr_valid_l), .buf_ptr_ready_l(buf_ptr_ready_l),
    .buf_ptr_data_r(buf_ptr_data_r), .buf_ptr_valid_r(buf_ptr_valid_r), .buf_ptr_ready_r(buf_ptr_ready_r),
    .param_addr_l(param_addr_l), .param_addr_valid_l(param_addr_valid_l), .param_addr_ready_l(param_addr_ready_l),
    .param_data_l(param_data_l), .param_data_valid_l(param_data_valid_l), .param_data_ready_l(param_data_ready_l),
    .w_sys_data(w_sys_data), .w_sys_valid(w_sys_valid), .w_sys_ready(w_sys_ready), .busy(busy)
  );

  // Memory contents: bank 0 of buffer 0 holds byte value 4*word+byte.
  function automatic logic [7:0] mem_byte(input int b, input int a, input int j);
    return 8'((a % DEPTH) * 4 + j + b * 100 + (a / DEPTH) * 50);
  endfunction

  function automatic logic [SW-1:0] mem_word(input int b, input int a);
    logic [SW-1:0] w;
    for (int j = 0; j < ELEMS; j++) w[j*WB +: WB] = mem_byte(b, a, j);
    return w;
  endfunction

  // Two-cycle read latency BRAM model
  logic [AW-1:0] p1 [NB];
  logic [AW-1:0] p2 [NB];
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      p1[b] <= addrB[b*AW +: AW];
      p2[b] <= p1[b];
    end
  end
  always_comb begin
    diB = '0;
    for (int b = 0; b < NB; b++) diB[b*SW +: SW] = mem_word(b, int'(p2[b]));
  end

  int checks = 0, errors = 0;
  int n_layers;
  int l_words [8];
  int l_reps  [8];
  int l_buf   [8];
  bit l_last  [8];
  logic [NB*WB-1:0] q_beat [$];
  logic [NB*WB-1:0] q_exp  [$];
  int q_addr [$], q_eaddr [$], q_rel [$], q_paddr [$];
  int max_occ, proto_bad, hold_bad, timed_out;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic build_expected();
    logic [NB*WB-1:0] bt;
    q_exp.delete();
    q_eaddr.delete();
    for (int l = 0; l < n_layers; l++)
      for (int r = 0; r < l_reps[l]; r++)
        for (int w = 0; w < l_words[l]; w++) begin
          q_eaddr.push_back(l_buf[l] * DEPTH + w);
          for (int k = 0; k < ELEMS; k++) begin
            for (int b = 0; b < NB; b++) bt[b*WB +: WB] = mem_byte(b, l_buf[l] * DEPTH + w, k);
            q_exp.push_back(bt);
          end
        end
  endtask

  task automatic run_seq(input int ready_pct, input int rel_hold, input int abort_issues);
    int pl = 0, bl = 0, rl = 0, hold = 0, issued = 0, beats = 0, cyc = 0, li, bi;
    logic [NB*WB-1:0] hold_data;
    logic hold_ptr;
    build_expected();
    q_beat.delete(); q_addr.delete(); q_rel.delete(); q_paddr.delete();
    max_occ = 0; proto_bad = 0; hold_bad = 0; timed_out = 0;
    hold_data = '0; hold_ptr = 1'b0;
    while (1) begin
      @(negedge clk);
      li = (pl < n_layers) ? pl : 0;
      bi = (bl < n_layers) ? bl : 0;
      start              = (cyc == 0);
      param_addr_ready_l = 1'b1;
      param_data_valid_l = (pl < n_layers);
      param_data_l       = {l_last[li], REP_W'(l_reps[li] - 1), WW'(l_words[li] - 1)};
      buf_ptr_valid_l    = (bl < n_layers);
      buf_ptr_data_l     = l_buf[bi][0];
      buf_ptr_ready_r    = buf_ptr_valid_r && (hold >= rel_hold);
      w_sys_ready        = ($urandom_range(99) < ready_pct);
      #1;
      if (weB !== '0) proto_bad++;
      if (enaB[0] === 1'b1) begin
        if (enaB[1] !== 1'b1 || addrB[2*AW-1:AW] !== addrB[AW-1:0]) proto_bad++;
        q_addr.push_back(int'(addrB[AW-1:0]));
        issued++;
      end else if (enaB[1] !== 1'b0) proto_bad++;
      if (param_addr_valid_l && param_addr_ready_l) q_paddr.push_back(int'(param_addr_l));
      if (param_data_valid_l && param_data_ready_l) pl++;
      if (buf_ptr_valid_l && buf_ptr_ready_l) bl++;
      if (w_sys_valid && w_sys_ready) begin
        q_beat.push_back(w_sys_data);
        beats++;
      end
      if (issued - beats / ELEMS > max_occ) max_occ = issued - beats / ELEMS;
      if (buf_ptr_valid_r) begin
        if (param_addr_valid_l) hold_bad++;
        if (hold == 0) begin
          hold_data = w_sys_data;
          hold_ptr  = buf_ptr_data_r;
        end else if (w_sys_data !== hold_data || buf_ptr_data_r !== hold_ptr || w_sys_valid) hold_bad++;
        if (buf_ptr_ready_r) begin
          q_rel.push_back(int'(buf_ptr_data_r));
          hold = 0;
          rl++;
        end else hold++;
      end
      cyc++;
      if (rl == n_layers) break;
      if (abort_issues > 0 && issued >= abort_issues) break;
      if (cyc > 5000) begin
        timed_out = 1;
        break;
      end
    end
    if (abort_issues == 0) begin
      @(negedge clk);
      start = 0; param_data_valid_l = 0; buf_ptr_valid_l = 0;
      buf_ptr_ready_r = 0; w_sys_ready = 0; param_addr_ready_l = 0;
    end
  endtask

  task automatic check_run(input string tag);
    int bad;
    chk({tag, "_timeout"}, timed_out, 0);
    chk({tag, "_beat_count"}, q_beat.size(), q_exp.size());
    bad = 0;
    for (int i = 0; i < q_beat.size() && i < q_exp.size(); i++) if (q_beat[i] !== q_exp[i]) bad++;
    chk({tag, "_beat_data_errs"}, bad, 0);
    chk({tag, "_read_count"}, q_addr.size(), q_eaddr.size());
    bad = 0;
    for (int i = 0; i < q_addr.size() && i < q_eaddr.size(); i++) if (q_addr[i] != q_eaddr[i]) bad++;
    chk({tag, "_read_addr_errs"}, bad, 0);
    chk({tag, "_release_count"}, q_rel.size(), n_layers);
    bad = 0;
    for (int i = 0; i < q_rel.size() && i < n_layers; i++) if (q_rel[i] != l_buf[i]) bad++;
    chk({tag, "_release_ptr_errs"}, bad, 0);
    chk({tag, "_param_req_count"}, q_paddr.size(), n_layers);
    bad = 0;
    for (int i = 0; i < q_paddr.size(); i++) if (q_paddr[i] != i) bad++;
    chk({tag, "_param_addr_errs"}, bad, 0);
    chk({tag, "_occupancy_le4"}, (max_occ <= LAT + 2), 1);
    chk({tag, "_protocol_errs"}, proto_bad, 0);
    chk({tag, "_hold_errs"}, hold_bad, 0);
    repeat (2) @(negedge clk);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic set_layer(input int i, input int w, input int r, input bit last, input int bf);
    l_words[i] = w; l_reps[i] = r; l_last[i] = last; l_buf[i] = bf;
  endtask

  initial begin
    int bad;
    rst_n = 0; start = 0;
    buf_ptr_data_l = 0; buf_ptr_valid_l = 0; buf_ptr_ready_r = 0;
    param_addr_ready_l = 0; param_data_l = '0; param_data_valid_l = 0; w_sys_ready = 0;
    repeat (3) @(negedge clk);
    chk("reset_enaB", enaB, 0);
    chk("reset_addrB", addrB, 0);
    chk("reset_busy", busy, 0);
    chk("reset_w_sys_valid", w_sys_valid, 0);
    chk("reset_w_sys_data", w_sys_data, 0);
    rst_n = 1;
    @(negedge clk);

    n_layers = 1; set_layer(0, 3, 1, 1'b1, 0);
    run_seq(100, 0, 0);
    check_run("t1");
    bad = 0;
    for (int i = 0; i < 12 && i < q_beat.size(); i++) if (q_beat[i][7:0] !== 8'(i)) bad++;
    chk("t1_bank0_byte_order_errs", bad, 0);

    n_layers = 1; set_layer(0, 2, 3, 1'b1, 1);
    run_seq(100, 0, 0);
    check_run("t2");

    for (int t = 0; t < 3; t++) begin
      n_layers = 1;
      set_layer(0, int'($urandom_range(6, 1)), int'($urandom_range(3, 1)), 1'b1, int'($urandom_range(1)));
      run_seq(30, 0, 0);
      check_run($sformatf("t3_rand%0d", t));
    end

    n_layers = 2; set_layer(0, 2, 2, 1'b0, 0); set_layer(1, 3, 1, 1'b1, 1);
    run_seq(60, 5, 0);
    check_run("t4_two_layers");

    n_layers = 4;
    for (int l = 0; l < 4; l++)
      set_layer(l, int'($urandom_range(3, 1)), int'($urandom_range(2, 1)), 1'b0, int'($urandom_range(1)));
    run_seq(50, 1, 0);
    check_run("t5_layer_saturate");

    n_layers = 1; set_layer(0, 3, 2, 1'b1, 1);
    run_seq(100, 0, 2);
    #2 rst_n = 0;
    #1;
    chk("t6_rst_enaB", enaB, 0);
    chk("t6_rst_addrB", addrB, 0);
    chk("t6_rst_w_sys_valid", w_sys_valid, 0);
    chk("t6_rst_w_sys_data", w_sys_data, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_release_valid", buf_ptr_valid_r, 0);
    chk("t6_rst_release_count", q_rel.size(), 0);
    start = 0; param_data_valid_l = 0; buf_ptr_valid_l = 0;
    buf_ptr_ready_r = 0; w_sys_ready = 0; param_addr_ready_l = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("t6_idle_release_valid", buf_ptr_valid_r, 0);

    n_layers = 1; set_layer(0, 3, 1, 1'b1, 0);
    run_seq(100, 0, 0);
    check_run("t7_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wbram_rd_sequencer.md
WBRAM_RD_SEQUENCER -- requirements
Module: wbram_rd_sequencer

Interface
REQ-001 Params: STREAM_WIDTH=128 (BRAM word bits); WEIGHT_BIT=8; NUM_BANKS=16; NUM_BUFS=2 (buffers per bank); BUF_DEPTH=512 (words per buffer); BRAM_LATENCY=2 (read cycles, 1..4); MAX_NUM_LAYERS=4; REP_W=8.
REQ-002 Derived: ELEMS=STREAM_WIDTH/WEIGHT_BIT; BW=$clog2(NUM_BUFS); WW=$clog2(BUF_DEPTH); AW=$clog2(NUM_BUFS*BUF_DEPTH); PARAM_WIDTH=1+REP_W+WW.
REQ-003 Ports (name dir width meaning):
 clk in 1 clock; rst_n in 1 asynchronous active-low reset; start in 1 one-cycle pulse beginning a layer sequence at layer 0;
 addrB out NUM_BANKS*AW per-bank BRAM address; enaB out NUM_BANKS read enable; weB out NUM_BANKS write enable; diB in NUM_BANKS*STREAM_WIDTH read data;
 buf_ptr_data_l in BW full-buffer index; buf_ptr_valid_l in 1; buf_ptr_ready_l out 1;
 buf_ptr_data_r out BW released-buffer index; buf_ptr_valid_r out 1; buf_ptr_ready_r in 1;
 param_addr_l out $clog2(MAX_NUM_LAYERS)+1 layer index; param_addr_valid_l out 1; param_addr_ready_l in 1;
 param_data_l in PARAM_WIDTH {last, reps-1, words-1}; param_data_valid_l in 1; param_data_ready_l out 1;
 w_sys_data out NUM_BANKS*WEIGHT_BIT one weight per bank; w_sys_valid out 1 lockstep valid; w_sys_ready in 1; busy out 1.

Function
REQ-010 FSM states IDLE, PADDR, PDATA, WAITBUF, STREAM, DRAIN, RELEASE.
REQ-011 IDLE: start -> PADDR with layer=0; start ignored outside IDLE.
REQ-012 PADDR: param_addr_valid_l=1, param_addr_l=layer; on ready -> PDATA.
REQ-013 PDATA: param_data_ready_l=1; on valid capture words=f+1, reps=r+1, last -> WAITBUF.
REQ-014 WAITBUF: buf_ptr_ready_l=1; on valid capture buf; word_idx=0, rep=0 -> STREAM.
REQ-015 STREAM: read issued (all enaB=1, addrB[b]=buf*BUF_DEPTH+word_idx, identical all banks) only when outstanding+fifo_count < FIFO_DEPTH=BRAM_LATENCY+2.
REQ-016 Each issue advances word_idx; at words-1 it wraps to 0 and rep increments; issue after word words-1 of pass reps-1 -> DRAIN.
REQ-017 diB captured into word FIFO exactly BRAM_LATENCY cycles after issue (valid shift register); FIFO never overflows.
REQ-018 Unpacker: w_sys_valid=!fifo_empty; w_sys_data[b]=head[b][k*WEIGHT_BIT +: WEIGHT_BIT], k=0..ELEMS-1, LSB first; k advances on valid&ready; head popped when k=ELEMS-1 accepted, k->0.
REQ-019 Data holds stable while valid&!ready.
REQ-020 DRAIN: no issues; when outstanding=0 and FIFO empty and k=0 -> RELEASE.
REQ-021 RELEASE: buf_ptr_valid_r=1, buf_ptr_data_r=buf; on ready: last=1 -> IDLE, else layer+1 -> PADDR.
REQ-022 Layer index saturates at MAX_NUM_LAYERS-1: if last=0 there, return to IDLE.
REQ-023 weB=0 always; enaB=0 outside issue cycles.
REQ-024 busy=1 in every state except IDLE.
REQ-025 Total emitted beats per layer = words*reps*ELEMS exactly; pass order word 0..words-1 each rep.

Reset
REQ-030 rst_n low asynchronously: state=IDLE, all valid/ready/enaB/weB=0, addrB=0, counters/FIFO/pipeline cleared, w_sys_data=0.
REQ-031 Reset mid-STREAM discards in-flight reads; no buffer release issued.

Structure
REQ-040 Package wbram_pkg: state enum, param-field widths, param-word field offsets.
REQ-041 Sub-module wbram_word_fifo (parametrised depth/width sync FIFO, count output); one instance, width NUM_BANKS*STREAM_WIDTH.

Verification (STREAM_WIDTH=32, WEIGHT_BIT=8, NUM_BANKS=2, BRAM_LATENCY=2)
REQ-050 words=3, reps=1, ready=1 -> 12 beats, bank0 bytes in order 0..11 of words 0..2; release ptr=buf.
REQ-051 words=2, reps=3 -> 24 beats, word sequence 0,1,0,1,0,1; single release.
REQ-052 w_sys_ready toggled random 30% -> identical data sequence, no loss/duplication; outstanding+fifo never >4.
REQ-053 Two layers (last=0, then last=1), buffers 0 then 1 -> param_addr 0 then 1, releases 0 then 1, then IDLE, busy=0.
REQ-054 rst_n asserted mid-stream of word 1 -> outputs zero immediately; post-reset start re-fetches layer 0.
REQ-055 buf_ptr_valid_r held 5 cycles without ready -> data stable, no new param_addr request.
